// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, matrix geometry and helpers.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebounce = 2'd1,
    StHeld     = 2'd2,
    StRelease  = 2'd3
  } state_e;

  localparam int unsigned NumCols  = 4;
  localparam int unsigned NumRows  = 4;
  localparam int unsigned KeyCodeW = 4;
  localparam int unsigned CntW     = 4;

  // Index of the lowest set bit; callers only rely on it when exactly one bit is set.
  function automatic logic [1:0] onehot_idx(input logic [NumRows-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NumRows - 1; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_edge_detect.sv
// Two-flop synchroniser with a one-cycle rising-edge pulse, for the divider's scan clock.
module keypad_scanner_sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, debounced press/release detection, one pulse per press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                scan_clk,
  input  logic [NumRows-1:0]  row_in,
  output logic [NumCols-1:0]  col_out,
  output logic [KeyCodeW-1:0] key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam logic [CntW-1:0] DebTarget = CntW'(DEBOUNCE_SCANS);

  logic                scan_tick;
  logic [NumRows-1:0]  row_meta_q, row_sync_q;
  state_e              state_q, state_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [1:0]          col_q, col_d;
  logic [1:0]          row_q, row_d;
  logic [KeyCodeW-1:0] code_q, code_d;
  logic                valid_q, valid_d;

  keypad_scanner_sync_edge_detect u_scan_sync (
    .clk_i  (clock_in),
    .rst_i  (reset),
    .d_i    (scan_clk),
    .rise_o (scan_tick)
  );

  logic [NumRows-1:0] rows_low;
  logic               one_low, all_high, match;
  logic [1:0]         hit_idx, col_next;
  logic [CntW-1:0]    cnt_inc;

  always_comb begin
    rows_low = ~row_sync_q;
    all_high = (rows_low == '0);
    one_low  = !all_high && ((rows_low & (rows_low - 4'd1)) == '0);
    hit_idx  = onehot_idx(rows_low);
    match    = one_low && (hit_idx == row_q);
    col_next = col_q + 2'd1;
    cnt_inc  = (count_q == '1) ? count_q : count_q + 4'd1;
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      state_q    <= StScan;
      count_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
      state_q    <= state_d;
      count_q    <= count_d;
      col_q      <= col_d;
      row_q      <= row_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    col_d   = col_q;
    row_d   = row_q;
    code_d  = code_q;
    valid_d = 1'b0;
    if (scan_tick) begin
      unique case (state_q)
        StScan: begin
          if (one_low) begin
            row_d   = hit_idx;
            count_d = 4'd1;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = StHeld;
              valid_d = 1'b1;
              code_d  = {hit_idx, col_q};
            end else begin
              state_d = StDebounce;
            end
          end else begin
            // No key or ghosting: keep scanning.
            col_d = col_next;
          end
        end
        StDebounce: begin
          if (match) begin
            count_d = cnt_inc;
            if (cnt_inc == DebTarget) begin
              state_d = StHeld;
              valid_d = 1'b1;
              code_d  = {row_q, col_q};
            end
          end else begin
            count_d = '0;
            state_d = StScan;
            col_d   = col_next;
          end
        end
        StHeld: begin
          if (all_high) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d = StScan;
              count_d = '0;
              col_d   = col_next;
            end else begin
              state_d = StRelease;
              count_d = 4'd1;
            end
          end
        end
        StRelease: begin
          if (all_high) begin
            count_d = cnt_inc;
            if (cnt_inc == DebTarget) begin
              state_d = StScan;
              count_d = '0;
              col_d   = col_next;
            end
          end else begin
            // Bounce on release: back to held without a new pulse.
            state_d = StHeld;
            count_d = '0;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_comb begin
    col_out   = ~(4'b0001 << col_q);
    key_code  = code_q;
    key_valid = valid_q;
    key_held  = (state_q == StHeld) || (state_q == StRelease);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: a keypad matrix model drives rows from the column lines of two scanner instances.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_clk;
  logic [3:0] row_a, col_a, code_a, row_b, col_b, code_b;
  logic       valid_a, held_a, valid_b, held_b;
  logic [15:0] keys_a, keys_b;  // bit r*4+c set = key at row r, column c pressed
  int unsigned n_tests = 0, n_fail = 0;
  int unsigned vcnt_a = 0, vcnt_b = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] rows_for(input logic [15:0] k, input logic [3:0] col);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && !col[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  assign row_a = rows_for(keys_a, col_a);
  assign row_b = rows_for(keys_b, col_b);

  keypad_scanner #(.DEBOUNCE_SCANS(4)) u_dut_a (
    .clock_in  (clk),
    .reset     (reset),
    .scan_clk  (scan_clk),
    .row_in    (row_a),
    .col_out   (col_a),
    .key_code  (code_a),
    .key_valid (valid_a),
    .key_held  (held_a)
  );

  keypad_scanner #(.DEBOUNCE_SCANS(1)) u_dut_b (
    .clock_in  (clk),
    .reset     (reset),
    .scan_clk  (scan_clk),
    .row_in    (row_b),
    .col_out   (col_b),
    .key_code  (code_b),
    .key_valid (valid_b),
    .key_held  (held_b)
  );

  always @(negedge clk) begin
    if (valid_a) vcnt_a++;
    if (valid_b) vcnt_b++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk) scan_clk = 1'b1;
    repeat (8) @(negedge clk);
    scan_clk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    scan_clk = 1'b0;
    keys_a   = '0;
    keys_b   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_col", col_a, 4'b1110);
    check_eq("rst_code", code_a, 4'h0);
    check_eq("rst_held", held_a, 1'b0);
    check_eq("rst_valid", valid_a, 1'b0);
    reset = 1'b0;

    // Free scan, one step per tick, wrapping.
    tick(); check_eq("scan1", col_a, 4'b1101);
    tick(); check_eq("scan2", col_a, 4'b1011);
    tick(); check_eq("scan3", col_a, 4'b0111);
    tick(); check_eq("scan_wrap", col_a, 4'b1110);

    // Clean press at row 2, column 1.
    keys_a = 16'h1 << 9;
    tick(); check_eq("press_col", col_a, 4'b1101);
    repeat (3) tick();
    check_eq("press_early_valid", vcnt_a, 0);
    check_eq("press_early_held", held_a, 1'b0);
    tick();
    check_eq("press_valid", vcnt_a, 1);
    check_eq("press_code", code_a, 4'b1001);
    check_eq("press_held", held_a, 1'b1);
    check_eq("press_col_frozen", col_a, 4'b1101);
    keys_a = '0;
    repeat (3) tick();
    check_eq("rel_held_mid", held_a, 1'b1);
    tick();
    check_eq("rel_held_done", held_a, 1'b0);
    check_eq("rel_col_next", col_a, 4'b1011);
    check_eq("rel_no_valid", vcnt_a, 1);

    // Press bounce at row 1, column 2.
    for (int i = 0; i < 6; i++) begin
      keys_a = (i % 2 == 0) ? (16'h1 << 6) : 16'h0;
      tick();
    end
    check_eq("bounce_no_valid", vcnt_a, 1);
    check_eq("bounce_col", col_a, 4'b0111);
    keys_a = 16'h1 << 6;
    repeat (3) tick();
    check_eq("bounce_col_back", col_a, 4'b1011);
    repeat (3) tick();
    check_eq("bounce_wait_valid", vcnt_a, 1);
    check_eq("bounce_wait_held", held_a, 1'b0);
    tick();
    check_eq("bounce_valid", vcnt_a, 2);
    check_eq("bounce_code", code_a, 4'b0110);

    // Release bounce: one-tick glitch during release.
    keys_a = '0;
    tick(); check_eq("relb_held1", held_a, 1'b1);
    keys_a = 16'h1 << 6;
    tick(); check_eq("relb_held2", held_a, 1'b1);
    keys_a = '0;
    repeat (3) tick();
    check_eq("relb_held3", held_a, 1'b1);
    check_eq("relb_col_frozen", col_a, 4'b1011);
    tick();
    check_eq("relb_held_done", held_a, 1'b0);
    check_eq("relb_col", col_a, 4'b0111);
    check_eq("relb_no_valid", vcnt_a, 2);

    // Ghosting in column 3: rows 0 and 2 low together.
    keys_a = (16'h1 << 3) | (16'h1 << 11);
    tick();
    check_eq("ghost_col", col_a, 4'b1110);
    check_eq("ghost_held", held_a, 1'b0);
    check_eq("ghost_valid", vcnt_a, 2);

    // Asynchronous reset mid-debounce at column 1.
    keys_a = 16'h1 << 13;
    tick(); check_eq("rstm_col_pre", col_a, 4'b1101);
    tick(); check_eq("rstm_col_dbnc", col_a, 4'b1101);
    #2 reset = 1'b1;
    #1;
    check_eq("rstm_col", col_a, 4'b1110);
    check_eq("rstm_code", code_a, 4'h0);
    check_eq("rstm_held", held_a, 1'b0);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rstm_exit_col", col_a, 4'b1110);
    check_eq("rstm_exit_valid", vcnt_a, 2);
    keys_a = '0;

    // Single-scan debounce instance.
    keys_b = 16'h1 << 4;
    tick();
    check_eq("ds1_valid", vcnt_b, 1);
    check_eq("ds1_code", code_b, 4'b0100);
    check_eq("ds1_held", held_b, 1'b1);
    keys_b = '0;
    tick();
    check_eq("ds1_rel_held", held_b, 1'b0);
    check_eq("ds1_rel_col", col_b, 4'b1101);
    check_eq("ds1_rel_valid", vcnt_b, 1);

    // scan_clk stuck high: the rising edge gives one tick, then everything freezes.
    @(negedge clk) scan_clk = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("stuck_col0", col_a, 4'b0111);
    keys_a = 16'h1 << 3;
    repeat (1000) @(negedge clk);
    check_eq("stuck_col", col_a, 4'b0111);
    check_eq("stuck_held", held_a, 1'b0);
    check_eq("stuck_valid", vcnt_a, 2);
    scan_clk = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the calculator's 4x4 matrix keypad, debounces presses and emits one key code per press. Sits directly downstream of the clock divider: it consumes the divider's slow square-wave output as a scan-rate strobe and runs entirely in the fast `clock_in` domain. It feeds the calculator's key decoder / operand-entry logic with a 4-bit code and a one-cycle valid pulse.

## Interface
- `DEBOUNCE_SCANS`, default 4: consecutive matching scan ticks required to accept a press, and again to accept a release. Legal range is 1..15.
- `clock_in`  in  1: system clock, the same clock that drives the divider.
- `reset`  in  1: asynchronous, active-high reset.
- `scan_clk`  in  1: divider output, a slow square wave. It is sampled as data and never used as a clock.
- `row_in`  in  4: keypad rows. Active-low, externally pulled up, asynchronous.
- `col_out`  out  4: column drive. Active-low, exactly one bit low at all times.
- `key_code`  out  4: `{row_idx[1:0], col_idx[1:0]}` of the last accepted key.
- `key_valid`  out  1: one-cycle pulse when a new press is accepted.
- `key_held`  out  1: high while the accepted key remains pressed.

## Operation
- **Input synchronisers:** `scan_clk` and `row_in` each pass through a 2-FF synchroniser.
- **Scan tick:** `scan_tick` = synced `scan_clk` high AND its previous sample low. It is one `clock_in` cycle wide per divider period.
- **Column drive:** column index `col_idx` drives `col_out = ~(4'b0001 << col_idx)`.
- All FSM activity occurs only on `scan_tick`. Between ticks, state, counter and column hold.
- "Match" means the synced rows show exactly one low bit, equal to the latched row.
- **SCAN:**
  - Sample synced rows.
  - If exactly one row is low: latch `row_idx`, freeze `col_idx`, set count to 1, go to DEBOUNCE. If `DEBOUNCE_SCANS`==1, accept immediately and go to HELD.
  - If no row is low, or more than one row is low (ghosting): advance `col_idx` (3 wraps to 0) and stay in SCAN.
- **DEBOUNCE:**
  - On a match, increment count. When count reaches `DEBOUNCE_SCANS`, accept and go to HELD.
  - On a mismatch, or no row low: count resets to 0, go to SCAN, and advance the column.
- **Accept:** load `key_code`, pulse `key_valid`.
- **HELD:**
  - `key_held` is 1.
  - All rows high: count is 1, go to RELEASE. If `DEBOUNCE_SCANS`==1, go straight to SCAN with the column advanced.
  - Otherwise stay in HELD. Additional keys pressed meanwhile are ignored.
- **RELEASE:**
  - `key_held` stays 1.
  - All rows high: increment count. At `DEBOUNCE_SCANS`, go to SCAN, advance the column, clear `key_held`.
  - Any row low: go back to HELD with count 0, with no new `key_valid`. This is bounce on release.
- `key_code` holds its last value until the next accept.
- **Counter:** 4 bits, saturating, never wraps.

## Timing
- **Reset values:** `col_out`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, state SCAN, count 0. Row synchroniser resets to 4'hF, `scan_clk` synchroniser resets to 0.
- `scan_tick` is high in the cycle after the 2nd `clock_in` edge that samples `scan_clk` high.
- **Tick to state latency:** the FSM registers update on the next edge.
- `key_valid` and `key_code` are registered. Both change on the same edge as the DEBOUNCE→HELD transition. `key_valid` drops the following cycle.
- `col_out` changes on the edge that processes the tick.
- **Row settling:** rows are sampled a full divider period after the column changes, which is ample settling time.
- **Minimum press-to-`key_valid`:** `DEBOUNCE_SCANS` ticks after first detection, plus 3 `clock_in` cycles.
- **Reset mid-operation:** an asynchronous reset aborts any state immediately. No `key_valid` is emitted during or on exit from reset.
- **`scan_clk` stuck high or low:** no ticks occur and all state freezes.

## Structure
- **Shared include `keypad_defs.vh`:**
  - state encodings SCAN=0, DEBOUNCE=1, HELD=2, RELEASE=3
  - `NUM_COLS`=4, `NUM_ROWS`=4
  - `KEY_CODE_W`=4
- **Sub-module `sync_edge_detect`:** 2-FF synchroniser plus rising-edge pulse for `scan_clk`. It is reusable by other consumers of the divider output.
- The FSM and column/count registers live in `keypad_scanner`.

## Test plan
- **Reset:** assert `reset` mid-DEBOUNCE → all outputs at reset values asynchronously. After release, `col_out`=1110 and no `key_valid`.
- **Clean press:** `DEBOUNCE_SCANS`=4. Hold row 2 low while col 1 is driven, clean → exactly one `key_valid` with `key_code`=4'b1001 after the 4th tick. `key_held`=1 until 4 clean release ticks, then scanning resumes at col 2.
- **Press bounce:** rows toggle on alternate ticks for 6 ticks, then stable → no `key_valid` until 4 consecutive matches, then exactly one.
- **Release bounce:** a 1-tick low glitch during RELEASE → returns to HELD and no second `key_valid`. The key is accepted again only after a full release and a new press.
- **Ghosting and scan wrap:** two rows low in col 3 → no detection, column wraps to 0 (`col_out`=1110). With no keys pressed, `col_out` cycles 1110→1101→1011→0111→1110, one step per tick.
- **`DEBOUNCE_SCANS`=1 and held `scan_clk`:**
  - `DEBOUNCE_SCANS`=1: `key_valid` on the first detecting tick.
  - `scan_clk` held high for 1000 cycles: no state change.
